// File: rtl/micro_sequencer.sv
// Microprogram sequencer: holds the 10-bit uPC that addresses the microinstruction ROM.
// Applies jump, call and return decisions using a register-based return-address stack.
module micro_sequencer #(
  parameter int          STACK_DEPTH  = 4,
  parameter logic [9:0]  RESET_VECTOR = 10'h000
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       Hold,
  input  logic       pre_load,
  input  logic       is_BSR,
  input  logic       is_RET,
  input  logic [9:0] S,
  output logic [9:0] ADDR,
  output logic [3:0] depth,
  output logic       err_ovf,
  output logic       err_unf
);

  logic [9:0] addr_q, addr_d;
  logic [3:0] depth_q, depth_d;
  logic       err_ovf_q, err_ovf_d;
  logic       err_unf_q, err_unf_d;
  logic [9:0] stack_q [STACK_DEPTH];
  logic [9:0] stack_d [STACK_DEPTH];

  logic [9:0] addr_inc;
  logic [9:0] stack_top;

  assign addr_inc = addr_q + 10'd1;

  // The top entry sits at index depth-1; only consumed when depth is non-zero.
  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (4'(i) + 4'd1 == depth_q) stack_top = stack_q[i];
    end
  end

  always_comb begin
    addr_d    = addr_q;
    depth_d   = depth_q;
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    stack_d   = stack_q;
    if (!Hold) begin
      if (pre_load && is_RET) begin
        if (depth_q != 4'd0) begin
          addr_d  = stack_top;
          depth_d = depth_q - 4'd1;
        end else begin
          addr_d    = addr_inc;
          err_unf_d = 1'b1;
        end
      end else if (pre_load && is_BSR) begin
        // A call on a full stack still jumps; only the push is dropped.
        addr_d = S;
        if (depth_q < 4'(STACK_DEPTH)) begin
          for (int i = 0; i < STACK_DEPTH; i++) begin
            if (4'(i) == depth_q) stack_d[i] = addr_inc;
          end
          depth_d = depth_q + 4'd1;
        end else begin
          err_ovf_d = 1'b1;
        end
      end else if (pre_load) begin
        addr_d = S;
      end else begin
        addr_d = addr_inc;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      addr_q    <= RESET_VECTOR;
      depth_q   <= 4'd0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      depth_q   <= depth_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  // Stack contents are don't-care after reset because depth is cleared.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      stack_q[i] <= stack_d[i];
    end
  end

  assign ADDR    = addr_q;
  assign depth   = depth_q;
  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: jumps, nested calls/returns, stack limits,
// uPC wrap, Hold freeze and reset under Hold, against hand-computed values.
module tb_micro_sequencer;

  logic       clk;
  logic       rst_n;
  logic       hold;
  logic       pre_load;
  logic       is_bsr;
  logic       is_ret;
  logic [9:0] s;
  logic [9:0] addr;
  logic [3:0] depth;
  logic       err_ovf;
  logic       err_unf;

  int n_checks = 0;
  int n_errors = 0;

  micro_sequencer #(
    .STACK_DEPTH (4),
    .RESET_VECTOR(10'h000)
  ) dut (
    .CLK     (clk),
    .RST_n   (rst_n),
    .Hold    (hold),
    .pre_load(pre_load),
    .is_BSR  (is_bsr),
    .is_RET  (is_ret),
    .S       (s),
    .ADDR    (addr),
    .depth   (depth),
    .err_ovf (err_ovf),
    .err_unf (err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then settle past the rising edge.
  task automatic drive(input logic rst_v, input logic hold_v, input logic pl_v,
                       input logic bsr_v, input logic ret_v, input logic [9:0] s_v);
    @(negedge clk);
    rst_n    = rst_v;
    hold     = hold_v;
    pre_load = pl_v;
    is_bsr   = bsr_v;
    is_ret   = ret_v;
    s        = s_v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
  endtask

  task automatic jump(input logic [9:0] t);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, t);
  endtask

  task automatic call(input logic [9:0] t);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, t);
  endtask

  task automatic ret();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'h000);
  endtask

  task automatic expect_state(input string tag, input logic [9:0] a, input logic [3:0] d,
                              input logic ovf, input logic unf);
    check({tag, ".addr"},  16'(addr),    16'(a));
    check({tag, ".depth"}, 16'(depth),   16'(d));
    check({tag, ".ovf"},   16'(err_ovf), 16'(ovf));
    check({tag, ".unf"},   16'(err_unf), 16'(unf));
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; pre_load = 1'b0; is_bsr = 1'b0; is_ret = 1'b0; s = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h155);
    expect_state("reset", 10'h000, 4'd0, 1'b0, 1'b0);

    for (int i = 1; i <= 5; i++) begin
      idle();
      expect_state("freerun", 10'(i), 4'd0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 11; i++) idle();
    check("reach_010", 16'(addr), 16'h0010);
    jump(10'h200);
    expect_state("jump_200", 10'h200, 4'd0, 1'b0, 1'b0);

    jump(10'h020);
    check("jump_020", 16'(addr), 16'h0020);
    call(10'h300);
    expect_state("bsr_300", 10'h300, 4'd1, 1'b0, 1'b0);
    idle();
    check("sub_301", 16'(addr), 16'h0301);
    idle();
    check("sub_302", 16'(addr), 16'h0302);
    ret();
    expect_state("ret_021", 10'h021, 4'd0, 1'b0, 1'b0);

    call(10'h100);
    expect_state("nest1", 10'h100, 4'd1, 1'b0, 1'b0);
    call(10'h110);
    expect_state("nest2", 10'h110, 4'd2, 1'b0, 1'b0);
    call(10'h120);
    expect_state("nest3", 10'h120, 4'd3, 1'b0, 1'b0);
    call(10'h130);
    expect_state("nest4", 10'h130, 4'd4, 1'b0, 1'b0);
    call(10'h140);
    expect_state("nest5_ovf", 10'h140, 4'd4, 1'b1, 1'b0);
    ret();
    expect_state("pop4", 10'h121, 4'd3, 1'b1, 1'b0);
    ret();
    expect_state("pop3", 10'h111, 4'd2, 1'b1, 1'b0);
    ret();
    expect_state("pop2", 10'h101, 4'd1, 1'b1, 1'b0);
    ret();
    expect_state("pop1", 10'h022, 4'd0, 1'b1, 1'b0);
    ret();
    expect_state("pop_unf", 10'h023, 4'd0, 1'b1, 1'b1);

    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h3AA);
    expect_state("bsr_no_pl", 10'h024, 4'd0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h3AA);
    expect_state("ret_no_pl", 10'h025, 4'd0, 1'b1, 1'b1);

    jump(10'h3FE);
    idle();
    check("wrap_3ff", 16'(addr), 16'h03FF);
    idle();
    check("wrap_000", 16'(addr), 16'h0000);
    jump(10'h3FF);
    call(10'h050);
    expect_state("bsr_at_3ff", 10'h050, 4'd1, 1'b1, 1'b1);
    ret();
    expect_state("ret_to_000", 10'h000, 4'd0, 1'b1, 1'b1);

    call(10'h200);
    check("pri_call", 16'(depth), 16'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'h155);
    expect_state("ret_over_bsr", 10'h001, 4'd0, 1'b1, 1'b1);

    call(10'h080);
    call(10'h090);
    expect_state("pre_hold", 10'h090, 4'd2, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'h2AA);
      expect_state("hold", 10'h090, 4'd2, 1'b1, 1'b1);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'h2AA);
    expect_state("rst_in_hold", 10'h000, 4'd0, 1'b0, 1'b0);
    idle();
    expect_state("post_rst", 10'h001, 4'd0, 1'b0, 1'b0);
    ret();
    expect_state("post_rst_ret", 10'h002, 4'd0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
